// File: rtl/cpu_clken_gen.sv
// Purpose: derive the Z80 clock-enable strobe from clk28 at 3.5/7/14/28 MHz with glitch-free speed changes.
// Latency: strobe is registered, one cycle after the phase wrap; request sampled each cycle, RUN->ALIGN in 1 cycle.
// Backpressure: contention_hold freezes the phase (stretches the CPU cycle); the settle gap ignores the hold.
module cpu_clken_gen #(
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic [3:0] cpu_speed,
    input  logic       contention_hold,
    output logic       cpu_clken,
    output logic [1:0] speed_active,
    output logic       switching
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    // Last phase value of a CPU cycle for each speed code (period minus one).
    function automatic logic [2:0] last_phase(input logic [1:0] code);
        case (code)
            2'b00:   last_phase = 3'd7;
            2'b01:   last_phase = 3'd3;
            2'b10:   last_phase = 3'd1;
            default: last_phase = 3'd0;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [1:0] active_q, active_d;
    logic [1:0] target_q, target_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] phase_q, phase_d;
    logic       clken_q, clken_d;

    logic [1:0] req;
    logic       advancing;
    logic       at_last;
    logic       wrap;
    logic       unused_speed_bits;

    // Upper speed bits are reserved and deliberately ignored.
    assign req               = cpu_speed[1:0];
    assign unused_speed_bits = ^cpu_speed[3:2];

    assign advancing = ((state_q == ST_RUN) || (state_q == ST_ALIGN)) && !contention_hold;
    assign at_last   = (phase_q == last_phase(active_q));
    assign wrap      = advancing && at_last;

    // State register: all control and datapath flops, cleared asynchronously.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            active_q <= 2'b00;
            target_q <= 2'b00;
            settle_q <= 4'd0;
            phase_q  <= 3'd0;
            clken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            target_q <= target_d;
            settle_q <= settle_d;
            phase_q  <= phase_d;
            clken_q  <= clken_d;
        end
    end

    // Next-state logic: track the requested speed, finish the old cycle, then count the settle gap.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        settle_d = settle_q;
        case (state_q)
            ST_RUN: begin
                if (req != active_q) begin
                    target_d = req;
                    state_d  = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (req == active_q) begin
                    // Request withdrawn before the old cycle ended: no gap needed.
                    state_d = ST_RUN;
                end else begin
                    target_d = req;
                    if (wrap) begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (req != target_q) begin
                    // A new request mid-gap restarts the full gap.
                    target_d = req;
                    settle_d = SETTLE_LOAD;
                end else if (settle_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output/datapath logic: phase counting, strobe scheduling and speed hand-over.
    always_comb begin
        clken_d  = wrap;
        active_d = active_q;
        if (!advancing) begin
            phase_d = phase_q;
        end else if (at_last) begin
            phase_d = 3'd0;
        end else begin
            phase_d = phase_q + 3'd1;
        end
        if ((state_q == ST_ALIGN) && (state_d == ST_SETTLE)) begin
            phase_d = 3'd0;
        end
        if ((state_q == ST_SETTLE) && (state_d == ST_RUN)) begin
            active_d = target_q;
            phase_d  = 3'd0;
        end
    end

    assign cpu_clken    = clken_q;
    assign speed_active = active_q;
    assign switching    = (state_q != ST_RUN);

endmodule

// File: tb/tb_cpu_clken_gen.sv
module tb_cpu_clken_gen;

    logic       clk28;
    logic       rst;
    logic [3:0] cpu_speed;
    logic       contention_hold;
    logic       cpu_clken;
    logic [1:0] speed_active;
    logic       switching;

    int n_cmp;
    int n_mis;
    int cyc;

    cpu_clken_gen #(.SETTLE_CYCLES(8)) dut (
        .clk28           (clk28),
        .rst             (rst),
        .cpu_speed       (cpu_speed),
        .contention_hold (contention_hold),
        .cpu_clken       (cpu_clken),
        .speed_active    (speed_active),
        .switching       (switching)
    );

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_clk, input logic e_sw, input logic [1:0] e_sa);
        chk({tag, "_clken"}, {1'b0, cpu_clken}, {1'b0, e_clk});
        chk({tag, "_switching"}, {1'b0, switching}, {1'b0, e_sw});
        chk({tag, "_speed_active"}, speed_active, e_sa);
    endtask

    // Advance one clk28 edge and sample just after it; cyc then names the cycle being observed.
    task automatic step();
        @(posedge clk28);
        #1;
        cyc++;
    endtask

    // Release reset between edges so that the next edge is cycle 0's closing edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk28);
        @(posedge clk28);
        @(negedge clk28);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        n_cmp           = 0;
        n_mis           = 0;
        cyc             = 0;
        rst             = 1'b1;
        cpu_speed       = 4'b0000;
        contention_hold = 1'b0;

        // 1: 3.5 MHz from reset, strobes at 8, 16, 24
        cpu_speed = 4'b0000;
        do_reset();
        chk_all("t1_reset", 1'b0, 1'b0, 2'b00);
        while (cyc < 26) begin
            step();
            chk_all("t1_35mhz", (cyc % 8 == 0), 1'b0, 2'b00);
        end

        // 2: 28 MHz requested from reset: last slow strobe at 8, 8 idle, then every cycle from 17
        cpu_speed = 4'b0011;
        do_reset();
        chk_all("t2_reset", 1'b0, 1'b0, 2'b00);
        while (cyc < 25) begin
            step();
            chk_all("t2_to28", (cyc == 8) || (cyc >= 17), (cyc <= 15), (cyc >= 16) ? 2'b11 : 2'b00);
        end

        // 3: reach 7 MHz, then hold 5 cycles at phase 1 and 2 cycles at phase 3
        cpu_speed = 4'b0001;
        do_reset();
        chk_all("t3_reset", 1'b0, 1'b0, 2'b00);
        while (cyc < 60) begin
            contention_hold = ((cyc >= 29) && (cyc <= 33)) || (cyc == 48) || (cyc == 49);
            step();
            chk_all("t3_hold",
                    (cyc == 8) || (cyc == 20) || (cyc == 24) || (cyc == 28) || (cyc == 37) ||
                    (cyc == 41) || (cyc == 45) || (cyc == 51) || (cyc == 55) || (cyc == 59),
                    (cyc >= 1) && (cyc <= 15),
                    (cyc >= 16) ? 2'b01 : 2'b00);
        end
        contention_hold = 1'b0;

        // 4: request withdrawn during ALIGN: no gap, speed unchanged
        cpu_speed = 4'b0000;
        do_reset();
        chk_all("t4_reset", 1'b0, 1'b0, 2'b00);
        while (cyc < 26) begin
            cpu_speed = ((cyc >= 2) && (cyc < 5)) ? 4'b0001 : 4'b0000;
            step();
            chk_all("t4_abort", (cyc % 8 == 0) && (cyc > 0), (cyc >= 3) && (cyc <= 5), 2'b00);
        end

        // 5: request 10, change to 01 on the 4th settle cycle: gap restarts, 7 MHz from 24
        cpu_speed = 4'b0010;
        do_reset();
        chk_all("t5_reset", 1'b0, 1'b0, 2'b00);
        while (cyc < 33) begin
            cpu_speed = (cyc >= 11) ? 4'b0001 : 4'b0010;
            step();
            chk_all("t5_restart", (cyc == 8) || ((cyc >= 24) && (cyc % 4 == 0)),
                    (cyc >= 1) && (cyc <= 19), (cyc >= 20) ? 2'b01 : 2'b00);
        end

        // 6: asynchronous reset in mid-SETTLE discards the pending switch
        cpu_speed = 4'b0011;
        do_reset();
        while (cyc < 10) begin
            step();
        end
        chk_all("t6_settle", 1'b0, 1'b1, 2'b00);
        rst = 1'b1;
        #1;
        chk_all("t6_async", 1'b0, 1'b0, 2'b00);
        cpu_speed = 4'b0000;
        @(posedge clk28);
        @(negedge clk28);
        rst = 1'b0;
        cyc = 0;
        chk_all("t6_release", 1'b0, 1'b0, 2'b00);
        while (cyc < 17) begin
            step();
            chk_all("t6_after", (cyc % 8 == 0) && (cyc > 0), 1'b0, 2'b00);
        end

        // 7: reserved bits set, low bits 00: identical to 3.5 MHz, no switch
        cpu_speed = 4'b1100;
        do_reset();
        chk_all("t7_reset", 1'b0, 1'b0, 2'b00);
        while (cyc < 24) begin
            step();
            chk_all("t7_reserved", (cyc % 8 == 0) && (cyc > 0), 1'b0, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
